// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared data-memory arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package mem_arb_pkg;

    localparam int NUM_CORES  = 4;
    localparam int MC_W       = 13;

    // Base bit positions of the fields inside the memory controller word
    localparam int MC_DR_WE   = 0;
    localparam int MC_AR_RD   = 4;
    localparam int MC_DATA_RD = 8;
    localparam int MC_WREN    = 12;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        LOAD,
        WRITE,
        ACK
    } mem_arb_state_t;

    // Controller word to present while sitting in state st serving core g.
    // WRITE also pulses the DR write enable so the core's data register
    // follows the access that just took place.
    function automatic logic [MC_W-1:0] ctrl_word(input mem_arb_state_t st, input logic [1:0] g);
        logic [MC_W-1:0] w;
        logic [MC_W-1:0] one;
        w   = '0;
        one = {{(MC_W-1){1'b0}}, 1'b1};
        case (st)
            ADDR, WAIT: w = one << (MC_AR_RD + int'(g));
            LOAD:       w = (one << (MC_AR_RD + int'(g))) | (one << (MC_DR_WE + int'(g)));
            WRITE:      w = (one << (MC_AR_RD + int'(g))) | (one << (MC_DATA_RD + int'(g)))
                          | (one << MC_WREN) | (one << (MC_DR_WE + int'(g)));
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/acknowledge bundle and memory controller word.
// Handshake: a core raises req (with wr) and holds both until its ack bit
// pulses for one cycle; req is only looked at while the arbiter is idle.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] wr;
    logic [NUM_CORES-1:0] ack;
    logic [MC_W-1:0]      mem_ctrl;
    logic                 busy;
    logic [1:0]           grant_id;
    mem_arb_state_t       state;     // FSM state, exposed for monitors

    modport master (
        output req, wr,
        input  ack, mem_ctrl, busy, grant_id, state
    );

    modport slave (
        input  req, wr,
        output ack, mem_ctrl, busy, grant_id, state
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational request picker.
// MEM_ARB_ROUND_ROBIN_EN defined: search upward from ptr+1 (mod 4).
// Otherwise: fixed priority, core 0 highest; no pointer input exists.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_CORES-1:0] req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic [1:0]           ptr,
`endif
    output logic                 valid,
    output logic [1:0]           idx
);

    logic [1:0] cand;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Walk offsets from farthest to nearest so the nearest requester after ptr wins
    always_comb begin
        valid = |req;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) idx = cand;
        end
    end
`else
    // Walk from lowest to highest priority so core 0 overrides everyone
    always_comb begin
        valid = |req;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = 2'(k);
            if (req[cand]) idx = cand;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Sequencer/arbiter for the shared data-memory port of four cores.
// Every output is registered from the next-state decode, so outputs always
// describe the state currently held and no req/wr path reaches an output.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin picker and pointer).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int READ_WAIT = 0     // extra read wait cycles, 0..3
) (
    input logic           clk,
    input logic           rstn,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] WAIT_INIT = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;

    mem_arb_state_t       state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [MC_W-1:0]      ctrl_q;
    logic [NUM_CORES-1:0] ack_q;
    logic                 busy_q;
    logic                 pick_valid;
    logic [1:0]           pick_idx;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q;

    mem_arb_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Pointer remembers the last granted core; reset to 3 so core 0 goes first
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= 2'd3;
        end else if (state_q == IDLE && pick_valid) begin
            ptr_q <= pick_idx;
        end
    end
`else
    mem_arb_pick u_pick (
        .req   (bus.req),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
`endif

    // Next-state decode; req is only considered in IDLE
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = bus.wr[pick_idx] ? WRITE : ADDR;
                end
            end
            ADDR: begin
                if (READ_WAIT > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = LOAD;
                else               cnt_d   = cnt_q - 2'd1;
            end
            LOAD:    state_d = ACK;
            WRITE:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, all derived from the state being entered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            cnt_q   <= 2'd0;
            ctrl_q  <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_word(state_d, grant_d);
            ack_q   <= (state_d == ACK) ? (4'b0001 << grant_d) : 4'b0000;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.mem_ctrl = ctrl_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + random bench for mem_arbiter with a small memory/DR model.
// Two instances: READ_WAIT=0 (main) and READ_WAIT=2 (wait-state checks).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int W = 20;  // {busy, grant_id[1:0], ack[3:0], mem_ctrl[12:0]}

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_arbiter_if bus0 ();
    mem_arbiter_if bus2 ();

    mem_arbiter #(.READ_WAIT(0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(bus0.slave));
    mem_arbiter #(.READ_WAIT(2)) u_dut2 (.clk(clk), .rstn(rstn), .bus(bus2.slave));

    int n_vec = 0;
    int n_mis = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   gnt_q[$];

    // ---------------- memory / data register model for bus0 ----------------
    logic [15:0] mem [256];
    logic [7:0]  c_addr [4];
    logic [15:0] c_wdata [4];
    logic [15:0] dr [4];

    function automatic logic [15:0] pat(input int a);
        return 16'((a * 257) ^ 16'h3C5A);
    endfunction

    function automatic logic bit_at(input logic [12:0] v, input int n);
        logic [12:0] s;
        s = v >> n;
        return s[0];
    endfunction

    always @(posedge clk) begin
        logic [7:0] ra;
        if (!rstn) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else begin
            ra = 8'd0;
            for (int i = 0; i < 4; i++)
                if (bit_at(bus0.mem_ctrl, MC_AR_RD + i)) ra = c_addr[i];
            for (int i = 0; i < 4; i++) begin
                if (bit_at(bus0.mem_ctrl, MC_DR_WE + i)) dr[i] <= mem[ra];
                if (bit_at(bus0.mem_ctrl, MC_WREN) && bit_at(bus0.mem_ctrl, MC_DATA_RD + i))
                    mem[c_addr[i]] <= c_wdata[i];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic b, input logic [1:0] g,
                                          input logic [3:0] a, input logic [12:0] mc);
        return {b, g, a, mc};
    endfunction

    function automatic logic [W-1:0] obs(input int sel);
        if (sel == 0) return {bus0.busy, bus0.grant_id, bus0.ack, bus0.mem_ctrl};
        return {bus2.busy, bus2.grant_id, bus2.ack, bus2.mem_ctrl};
    endfunction

    task automatic set_req(input int sel, input int g, input logic r, input logic w);
        if (sel == 0) begin
            bus0.req[g] = r;
            bus0.wr[g]  = w;
        end else begin
            bus2.req[g] = r;
            bus2.wr[g]  = w;
        end
    endtask

    // One isolated transaction: expected per-cycle words are queued up front,
    // then popped one per cycle; req is dropped in the ack cycle.
    task automatic run_txn(input int sel, input int rw, input int g, input logic is_wr,
                           input logic [7:0] addr, input logic [15:0] wdata,
                           input logic chk_dr, input logic [15:0] exp_dr, input string tag);
        logic [12:0] one, ar, drb;
        logic [1:0]  gg;
        logic [W-1:0] e;
        one = 13'd1;
        gg  = 2'(g);
        ar  = one << (4 + g);
        drb = one << g;
        if (is_wr) begin
            exp_q.push_back(pack(1'b1, gg, 4'd0, ar | (one << (8 + g)) | (one << 12) | drb));
        end else begin
            exp_q.push_back(pack(1'b1, gg, 4'd0, ar));
            for (int k = 0; k < rw; k++) exp_q.push_back(pack(1'b1, gg, 4'd0, ar));
            exp_q.push_back(pack(1'b1, gg, 4'd0, ar | drb));
        end
        exp_q.push_back(pack(1'b1, gg, 4'd1 << g, 13'd0));
        exp_q.push_back(pack(1'b0, gg, 4'd0, 13'd0));
        c_addr[g]  = addr;
        c_wdata[g] = wdata;
        set_req(sel, g, 1'b1, is_wr);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            chk(tag, 32'(obs(sel)), 32'(e));
            if (e[16:13] != 4'd0) begin
                set_req(sel, g, 1'b0, 1'b0);
                if (chk_dr) chk({tag, "_dr"}, 32'(dr[g]), 32'(exp_dr));
            end
        end
    endtask

    task automatic check_inv();
        logic [12:0] mc;
        mc = bus0.mem_ctrl;
        chk("inv_dr_onehot", 32'($onehot0(mc[3:0])), 32'd1);
        chk("inv_ar_onehot", 32'($onehot0(mc[7:4])), 32'd1);
        chk("inv_ds_onehot", 32'($onehot0(mc[11:8])), 32'd1);
        chk("inv_ack_onehot", 32'($onehot0(bus0.ack)), 32'd1);
        chk("inv_we_ds", 32'(!mc[12] || (mc[11:8] != 4'd0)), 32'd1);
        chk("inv_we_state", 32'(!mc[12] || (bus0.state == WRITE)), 32'd1);
        chk("inv_ar_ds", 32'((mc[11:8] == 4'd0) || (mc[11:8] == mc[7:4])), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] eg;
        logic       found;
        logic [3:0] prev_req;
        logic       prev_busy;
        int         grants, acks;

        rstn      = 1'b0;
        bus0.req  = '0;
        bus0.wr   = '0;
        bus2.req  = '0;
        bus2.wr   = '0;
        for (int i = 0; i < 4; i++) begin
            c_addr[i]  = 8'd0;
            c_wdata[i] = 16'd0;
        end
        tick();
        tick();

        // reset values
        chk("rst_dut0", 32'(obs(0)), 32'(pack(1'b0, 2'd0, 4'd0, 13'd0)));
        chk("rst_dut2", 32'(obs(2)), 32'(pack(1'b0, 2'd0, 4'd0, 13'd0)));
        chk("rst_state", 32'(bus0.state), 32'(IDLE));
        rstn = 1'b1;
        tick();
        chk("idle_no_req", 32'(obs(0)), 32'(pack(1'b0, 2'd0, 4'd0, 13'd0)));

        // single write / read-back, plus reads of untouched memory
        run_txn(0, 0, 0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 16'h0, "wr_c0");
        run_txn(0, 0, 2, 1'b0, 8'h10, 16'h0, 1'b1, 16'hBEEF, "rd_c2");
        run_txn(0, 0, 1, 1'b0, 8'h21, 16'h0, 1'b1, pat(8'h21), "rd_c1");
        run_txn(0, 0, 3, 1'b1, 8'h40, 16'h1234, 1'b0, 16'h0, "wr_c3");
        run_txn(0, 0, 3, 1'b0, 8'h40, 16'h0, 1'b1, 16'h1234, "rd_c3");
        run_txn(0, 0, 0, 1'b0, 8'hFF, 16'h0, 1'b1, pat(8'hFF), "rd_c0");

        // wait states on the READ_WAIT=2 instance
        run_txn(2, 2, 1, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0, "rw2_rd_c1");
        run_txn(2, 2, 2, 1'b1, 8'h00, 16'h0, 1'b0, 16'h0, "rw2_wr_c2");
        run_txn(2, 2, 3, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0, "rw2_rd_c3");

        // contention with all four requests held, starting from reset
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gnt_q.push_back(2'(k % 4));
`else
            gnt_q.push_back(2'd0);
`endif
        end
        bus0.wr  = 4'b0000;
        bus0.req = 4'b1111;
        for (int cyc = 0; cyc < 60 && gnt_q.size() > 0; cyc++) begin
            tick();
            if (bus0.ack != 4'd0) begin
                eg = gnt_q.pop_front();
                chk("cont_ack", 32'(bus0.ack), 32'(4'd1 << eg));
                chk("cont_gid", 32'(bus0.grant_id), 32'(eg));
                if (gnt_q.size() == 0) bus0.req = 4'b0000;
            end
        end
        chk("cont_done", 32'(gnt_q.size()), 32'd0);
        gnt_q.delete();
        bus0.req = 4'b0000;
        tick();
        tick();

        // reset asserted while a read sits in LOAD
        bus0.req = 4'b0010;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (bus0.state == LOAD) found = 1'b1;
        end
        chk("rmr_reach_load", 32'(found), 32'd1);
        rstn = 1'b0;
        tick();
        chk("rmr_outputs", 32'(obs(0)), 32'(pack(1'b0, 2'd0, 4'd0, 13'd0)));
        chk("rmr_state", 32'(bus0.state), 32'(IDLE));
        bus0.req = 4'b0000;
        tick();
        chk("rmr_no_ack", 32'(obs(0)), 32'(pack(1'b0, 2'd0, 4'd0, 13'd0)));
        rstn     = 1'b1;
        bus0.req = 4'b1111;
        tick();
        chk("rmr_first_gid", 32'(bus0.grant_id), 32'd0);
        chk("rmr_first_busy", 32'(bus0.busy), 32'd1);
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (bus0.ack != 4'd0) begin
                found = 1'b1;
                chk("rmr_first_ack", 32'(bus0.ack), 32'd1);
                bus0.req = 4'b0000;
            end
        end
        chk("rmr_ack_seen", 32'(found), 32'd1);
        bus0.req = 4'b0000;
        tick();
        tick();

        // random traffic with invariant monitor and grant/ack scoreboard
        prev_busy = 1'b0;
        prev_req  = 4'b0000;
        grants    = 0;
        acks      = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            check_inv();
            if (bus0.busy && !prev_busy) begin
                gnt_q.push_back(bus0.grant_id);
                grants++;
                chk("rnd_gnt_req", 32'(prev_req[bus0.grant_id]), 32'd1);
            end
            if (bus0.ack != 4'd0) begin
                acks++;
                if (gnt_q.size() == 0) begin
                    chk("rnd_ack_extra", 32'(bus0.ack), 32'd0);
                end else begin
                    eg = gnt_q.pop_front();
                    chk("rnd_ack", 32'(bus0.ack), 32'(4'd1 << eg));
                end
            end
            prev_busy = bus0.busy;
            for (int i = 0; i < 4; i++) begin
                if (bus0.req[i] && bus0.ack[i]) begin
                    bus0.req[i] = 1'b0;
                end else if (!bus0.req[i] && cyc < 550 && $urandom_range(0, 3) == 0) begin
                    c_addr[i]   = 8'($urandom_range(0, 255));
                    c_wdata[i]  = 16'($urandom_range(0, 65535));
                    bus0.wr[i]  = 1'($urandom_range(0, 1));
                    bus0.req[i] = 1'b1;
                end
            end
            prev_req = bus0.req;
        end
        chk("rnd_drain", 32'(gnt_q.size()), 32'd0);
        chk("rnd_ack_count", 32'(acks), 32'(grants));
        chk("rnd_activity", 32'(grants > 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
